// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier controller.
//   OP_W   : operand width (8; bounded by the shared 12-bit adder)
//   ACC_W  : accumulator / adder width (12)
//   N_ITER : radix-4 digit count, (OP_W+2)/2
//   state_t: controller states
//   digit_t: recoded Booth digit, plus booth_digit() to decode a bit triplet
package booth_pkg;

  localparam int OP_W   = 8;
  localparam int ACC_W  = 12;
  localparam int N_ITER = (OP_W + 2) / 2;
  localparam int CNT_W  = 3;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_t;

  // Triplet order is {y[2i+1], y[2i], y[2i-1]}.
  function automatic digit_t booth_digit(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: booth_digit = POS1;
      3'b011:         booth_digit = POS2;
      3'b100:         booth_digit = NEG2;
      3'b101, 3'b110: booth_digit = NEG1;
      default:        booth_digit = ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder for one digit.
//   trip  : {y[2i+1], y[2i], y[2i-1]}
//   neg   : digit is negative (-X or -2X)
//   sel2x : digit magnitude is 2
//   zero  : digit is 0
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] trip,
  output logic       neg,
  output logic       sel2x,
  output logic       zero
);

  digit_t digit;

  assign digit = booth_digit(trip);
  assign neg   = (digit == NEG1) || (digit == NEG2);
  assign sel2x = (digit == POS2) || (digit == NEG2);
  assign zero  = (digit == ZERO);

endmodule

// File: rtl/cla_ripple_12bit.sv
// 12-bit adder/subtractor: three 4-bit carry-lookahead groups with the group
// carries rippled between them.
//   a, b : 12-bit operands
//   c0   : carry-in; 1 also inverts b, so the result is a - b
//   sum  : 12-bit result
//   c12  : carry-out
module cla_ripple_12bit (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        c0,
  output logic [11:0] sum,
  output logic        c12
);

  // Returns {carry-out, carries into bits 3..0} for one lookahead group.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic cin);
    logic [4:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & cin);
    return c;
  endfunction

  logic [11:0] bx;
  logic [11:0] g;
  logic [11:0] p;
  logic [4:0]  k0;
  logic [4:0]  k1;
  logic [4:0]  k2;

  assign bx  = b ^ {12{c0}};
  assign g   = a & bx;
  assign p   = a ^ bx;
  assign k0  = cla4(g[3:0],  p[3:0],  c0);
  assign k1  = cla4(g[7:4],  p[7:4],  k0[4]);
  assign k2  = cla4(g[11:8], p[11:8], k1[4]);
  assign sum = p ^ {k2[3:0], k1[3:0], k0[3:0]};
  assign c12 = k2[4];

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 modified-Booth multiplier controller, 8x8 unsigned -> 16.
// One shared cla_ripple_12bit adder is used for 5 iterations, one digit each.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand finishes in one cycle.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : request; accepted only while ready
//   mcand, mplier  : X and Y, captured on the accept edge
//   ready          : IDLE or DONE, start is accepted this cycle
//   busy           : RUN
//   done           : one-cycle pulse in DONE
//   product        : X*Y, held until the next accepted start completes
module booth_seq_mult_ctrl
  import booth_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   mcand,
  input  logic [OP_W-1:0]   mplier,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t                       state;
  state_t                       state_nxt;
  logic [OP_W-1:0]              x_q;
  logic [ACC_W-1:0]             acc_hi;
  logic [OP_W+1:0]              lo10;      // multiplier shifting out, product bits shifting in
  logic                         y_m1;      // y[2i-1] of the current digit
  logic [CNT_W-1:0]             cnt;
  logic [PROD_W-1:0]            product_q;

  logic                         accept;
  logic                         skip;
  logic                         last_iter;
  logic                         neg;
  logic                         sel2x;
  logic                         zero;
  logic [ACC_W-1:0]             add_b;
  logic [ACC_W-1:0]             add_sum;
  logic                         add_c12_unused;
  logic [ACC_W+OP_W+1:0]        shifted;

  assign ready     = (state != RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign product   = product_q;
  assign accept    = start && ready;
  assign last_iter = (cnt == CNT_W'(N_ITER - 1));

`ifdef BOOTH_ZERO_SKIP_EN
  assign skip = (mcand == '0) || (mplier == '0);
`else
  assign skip = 1'b0;
`endif

  booth_r4_recode u_recode (
    .trip  ({lo10[1:0], y_m1}),
    .neg   (neg),
    .sel2x (sel2x),
    .zero  (zero)
  );

  // |digit|*X, zero-extended; the sign is applied by the adder through c0.
  assign add_b = zero  ? '0
               : sel2x ? {{(ACC_W-OP_W-1){1'b0}}, x_q, 1'b0}
               :         {{(ACC_W-OP_W){1'b0}}, x_q};

  cla_ripple_12bit u_adder (
    .a   (acc_hi),
    .b   (add_b),
    .c0  (neg),
    .sum (add_sum),
    .c12 (add_c12_unused)
  );

  // Arithmetic shift by one radix-4 digit; the 12-bit wrap is intentional.
  assign shifted = $signed({add_sum, lo10}) >>> 2;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = skip ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN:     if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      acc_hi    <= '0;
      lo10      <= '0;
      y_m1      <= 1'b0;
      cnt       <= '0;
      product_q <= '0;
    end else if (accept) begin
      x_q    <= mcand;
      lo10   <= {2'b00, mplier};
      y_m1   <= 1'b0;
      acc_hi <= '0;
      cnt    <= '0;
      if (skip) product_q <= '0;
    end else if (state == RUN) begin
      {acc_hi, lo10} <= shifted;
      y_m1           <= lo10[1];
      cnt            <= cnt + 1'b1;
      if (last_iter) product_q <= shifted[PROD_W-1:0];
    end
  end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Scoreboard bench for booth_seq_mult_ctrl: stimulus pushes the expected
// product and latency, a negedge monitor pops and compares on every done.
module tb_booth_seq_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] product;

  typedef struct {
    logic [15:0] prod;
    int          accept_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  logic done_d = 1'b0;

  booth_seq_mult_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef BOOTH_ZERO_SKIP_EN
    return (x == 0 || y == 0) ? 1 : 5;
`else
    return 5;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    int t = 0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      check("ready_timeout", ready, 1);
      return;
    end
    mcand = x;
    mplier = y;
    start = 1'b1;
    sb.push_back('{16'(x) * 16'(y), cyc + 1, exp_lat(x, y)});
    @(negedge clk);
    start  = 1'b0;
    mcand  = 8'($urandom);
    mplier = 8'($urandom);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Monitor: handshake invariants every cycle, scoreboard pop on done.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_eq_not_busy", ready, !busy);
      if (done) begin
        check("done_single_cycle", done_d, 0);
        check("sb_nonempty_on_done", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("product", product, e.prod);
          check("latency", cyc - e.accept_cyc, e.lat);
        end
      end
      done_d = done;
    end else begin
      done_d = 1'b0;
    end
  end

  logic [7:0] vals[11] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd85, 8'd127,
                           8'd128, 8'd129, 8'd170, 8'd254, 8'd255};

  initial begin
    int b;
    int t;
    int d1;
    rst_n  = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(negedge clk);
    check("rst_product", product, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 255*255: busy exactly 5 cycles.
    issue(8'd255, 8'd255);
    b = 0;
    t = 0;
    while (!done && t < 20) begin
      if (busy) b++;
      @(negedge clk);
      t++;
    end
    check("busy_cycles_255x255", b, 5);

    // 170*85 with a start pulse mid-RUN that must be ignored.
    repeat (3) @(negedge clk);
    issue(8'd170, 8'd85);
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'd9;
    mplier = 8'd9;
    @(negedge clk);
    start  = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("product_hold", product, 14450);

    // Back-to-back: start held through DONE with new operands 3*5.
    repeat (4) @(negedge clk);
    mcand  = 8'd12;
    mplier = 8'd13;
    start  = 1'b1;
    sb.push_back('{16'd156, cyc + 1, 5});
    @(negedge clk);
    wait_done();
    d1 = cyc;
    mcand  = 8'd3;
    mplier = 8'd5;
    sb.push_back('{16'd15, cyc + 1, 5});
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("b2b_done_gap", cyc - d1, 6);

    // Reset in the 3rd RUN cycle of 200*201 aborts without a done.
    repeat (3) @(negedge clk);
    issue(8'd200, 8'd201);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("abort_product", product, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(8'd200, 8'd201);
    wait_done();
    @(negedge clk);

    // Zero operand: 1-cycle path only with BOOTH_ZERO_SKIP_EN.
    issue(8'd0, 8'd77);
    wait_done();
    @(negedge clk);

    // Corner-value cross product, issued back-to-back.
    foreach (vals[i])
      foreach (vals[j])
        issue(vals[i], vals[j]);

    t = 0;
    while (sb.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
